// File: rtl/spi_sensor_slave.sv
// SPI slave emulating a multi-channel sensor; oversampled on clk.
// Optional SPI_SENSOR_PARITY_EN appends an even-parity bit per word.
module spi_sensor_slave #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sample_valid,
  input  logic [CHANNELS*WIDTH-1:0] sample_data,
  input  logic                      csb,
  input  logic                      sck,
  input  logic                      sdi,
  output logic                      sdo,
  output logic                      sdo_oe,
  output logic                      busy,
  output logic                      word_done,
  output logic [7:0]                word_count
);

  localparam logic CPOL = 1'((MODE >> 1) & 1);
  localparam logic CPHA = 1'(MODE & 1);
`ifdef SPI_SENSOR_PARITY_EN
  localparam int SW = WIDTH + 1;
`else
  localparam int SW = WIDTH;
`endif
  localparam logic [5:0] LASTB  = 6'(SW - 1);
  localparam logic [4:0] LASTCH = 5'(CHANNELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    IGNORE
  } state_t;

  state_t state_q, state_d;

  logic csb_s1, csb_s2, csb_d;
  logic sck_s1, sck_s2, sck_d;
  logic sdi_s1, sdi_s2;

  logic csb_fall, csb_rise;
  logic sck_rise, sck_fall;
  logic lead_edge, trail_edge;
  logic samp_edge, shft_edge;
  logic cmd_last, word_last;

  logic [CHANNELS*WIDTH-1:0] live_q;
  logic [CHANNELS*WIDTH-1:0] snap_q;
  logic [6:0]                cmd_sr;
  logic [5:0]                bit_cnt;
  logic [3:0]                ptr;
  logic [3:0]                ptr_nxt;
  logic [SW-1:0]             sr;
  logic                      need_load;
  logic                      wd_pend;
  logic [WIDTH-1:0]          ch_word;
  logic [SW-1:0]             load_val;

  // Two-flop synchronisers plus one delay stage for edge detection.
  // csb stages reset low so a csb held low across reset is not a fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      csb_s1 <= 1'b0;
      csb_s2 <= 1'b0;
      csb_d  <= 1'b0;
      sck_s1 <= CPOL;
      sck_s2 <= CPOL;
      sck_d  <= CPOL;
      sdi_s1 <= 1'b0;
      sdi_s2 <= 1'b0;
    end else begin
      csb_s1 <= csb;
      csb_s2 <= csb_s1;
      csb_d  <= csb_s2;
      sck_s1 <= sck;
      sck_s2 <= sck_s1;
      sck_d  <= sck_s2;
      sdi_s1 <= sdi;
      sdi_s2 <= sdi_s1;
    end
  end

  assign csb_fall   = csb_d & ~csb_s2;
  assign csb_rise   = ~csb_d & csb_s2;
  assign sck_rise   = ~sck_d & sck_s2;
  assign sck_fall   = sck_d & ~sck_s2;
  assign lead_edge  = CPOL ? sck_fall : sck_rise;
  assign trail_edge = CPOL ? sck_rise : sck_fall;
  assign samp_edge  = CPHA ? trail_edge : lead_edge;
  assign shft_edge  = CPHA ? lead_edge : trail_edge;
  assign cmd_last   = samp_edge & (bit_cnt == 6'd7);
  assign word_last  = samp_edge & (bit_cnt == LASTB);

  // Snapshot word select; out-of-range pointers read as zero.
  always_comb begin
    ch_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ptr == 4'(k)) ch_word = snap_q[k*WIDTH +: WIDTH];
    end
`ifdef SPI_SENSOR_PARITY_EN
    load_val = {ch_word, ^ch_word};
`else
    load_val = ch_word;
`endif
    ptr_nxt = ({1'b0, ptr} >= LASTCH) ? 4'd0 : ptr + 4'd1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and pin outputs.
  always_comb begin
    state_d = state_q;
    sdo_oe  = 1'b0;
    busy    = 1'b0;
    sdo     = 1'b0;
    unique case (state_q)
      IDLE:   if (csb_fall) state_d = CMD;
      CMD:    if (cmd_last) state_d = cmd_sr[6] ? DATA : IGNORE;
      DATA:   state_d = DATA;
      IGNORE: state_d = IGNORE;
    endcase
    if (csb_rise) state_d = IDLE;
    sdo_oe = (state_q == DATA);
    busy   = (state_q != IDLE);
    sdo    = sdo_oe & sr[SW-1];
  end

  // Sample capture, command shift, data shift and word accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      live_q     <= '0;
      snap_q     <= '0;
      cmd_sr     <= '0;
      bit_cnt    <= '0;
      ptr        <= '0;
      sr         <= '0;
      need_load  <= 1'b0;
      wd_pend    <= 1'b0;
      word_done  <= 1'b0;
      word_count <= '0;
    end else begin
      if (sample_valid) live_q <= sample_data;
      if (csb_fall)     snap_q <= live_q;
      wd_pend   <= 1'b0;
      word_done <= wd_pend;
      if (wd_pend && word_count != 8'hFF)
        word_count <= word_count + 8'd1;
      unique case (state_q)
        IDLE: begin
          if (csb_fall) begin
            bit_cnt    <= '0;
            word_count <= '0;
            cmd_sr     <= '0;
            sr         <= '0;
            need_load  <= 1'b1;
          end
        end
        CMD: begin
          if (samp_edge) begin
            cmd_sr  <= {cmd_sr[5:0], sdi_s2};
            bit_cnt <= bit_cnt + 6'd1;
          end
          if (cmd_last) begin
            bit_cnt   <= '0;
            ptr       <= {cmd_sr[2:0], sdi_s2};
            need_load <= 1'b1;
          end
        end
        DATA: begin
          if (shft_edge) begin
            if (need_load) begin
              sr        <= load_val;
              need_load <= 1'b0;
            end else begin
              sr <= {sr[SW-2:0], 1'b0};
            end
          end
          if (samp_edge) bit_cnt <= bit_cnt + 6'd1;
          if (word_last) begin
            bit_cnt   <= '0;
            wd_pend   <= 1'b1;
            need_load <= 1'b1;
            ptr       <= ptr_nxt;
          end
        end
        IGNORE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sensor_slave.sv
// Randomised bench for spi_sensor_slave: MODE 0 and MODE 3 instances
// checked against a word-level snapshot model.
module tb_spi_sensor_slave;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int H  = 6;
`ifdef SPI_SENSOR_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [CH*W-1:0] sample_data = '0;
  logic [1:0]    csb = 2'b11;
  logic [1:0]    sck = 2'b10;
  logic [1:0]    sdi = 2'b00;
  logic [1:0]    sdo, sdo_oe, busy, word_done;
  logic [7:0]    wc0, wc1;

  int n_chk = 0;
  int n_err = 0;
  int wd_cnt[2] = '{0, 0};

  logic [W-1:0] live[CH];
  logic [W-1:0] snap[CH];
  logic [W-1:0] rx_w[16];
  logic         rx_p[16];

  always #5 clk = ~clk;

  spi_sensor_slave #(.WIDTH(W), .CHANNELS(CH), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .csb(csb[0]), .sck(sck[0]), .sdi(sdi[0]),
    .sdo(sdo[0]), .sdo_oe(sdo_oe[0]), .busy(busy[0]),
    .word_done(word_done[0]), .word_count(wc0)
  );

  spi_sensor_slave #(.WIDTH(W), .CHANNELS(CH), .MODE(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .csb(csb[1]), .sck(sck[1]), .sdi(sdi[1]),
    .sdo(sdo[1]), .sdo_oe(sdo_oe[1]), .busy(busy[1]),
    .word_done(word_done[1]), .word_count(wc1)
  );

  always @(posedge clk) begin
    if (word_done[0]) wd_cnt[0]++;
    if (word_done[1]) wd_cnt[1]++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic q(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load_ch(input logic [CH*W-1:0] v);
    sample_valid = 1'b1;
    sample_data  = v;
    @(posedge clk);
    #2;
    sample_valid = 1'b0;
    for (int k = 0; k < CH; k++) live[k] = v[k*W +: W];
  endtask

  function automatic logic [W-1:0] mword(input int p);
    return (p < CH) ? snap[p] : '0;
  endfunction

  task automatic spi_bit(input bit m, input logic bo,
                         output logic bi, output logic oe);
    logic cpol;
    cpol = m;
    if (!m) begin
      sdi[m] = bo;
      q(2);
      bi = sdo[m];
      oe = sdo_oe[m];
      sck[m] = ~cpol;
      q(H);
      sck[m] = cpol;
      q(H - 2);
    end else begin
      sck[m] = ~cpol;
      sdi[m] = bo;
      q(H);
      bi = sdo[m];
      oe = sdo_oe[m];
      sck[m] = cpol;
      q(H);
    end
  endtask

  task automatic spi_begin(input bit m);
    sck[m] = m;
    csb[m] = 1'b0;
    for (int k = 0; k < CH; k++) snap[k] = live[k];
    q(H);
  endtask

  task automatic spi_cmd(input bit m, input logic [7:0] cmd);
    logic b, o;
    for (int i = 7; i >= 0; i--) spi_bit(m, cmd[i], b, o);
  endtask

  task automatic spi_end(input bit m);
    q(2);
    csb[m] = 1'b1;
    q(H);
  endtask

  task automatic xfer(input bit m, input logic [7:0] cmd,
                      input int nw, input bit sv_mid);
    int p, wd0;
    logic bi, oe, anyoe;
    logic [NB-1:0] acc;
    logic [W-1:0] ew;
    anyoe = 1'b0;
    spi_begin(m);
    spi_cmd(m, cmd);
    wd0 = wd_cnt[m];
    p = int'(cmd[3:0]);
    for (int w = 0; w < nw; w++) begin
      acc = '0;
      for (int b = 0; b < NB; b++) begin
        spi_bit(m, 1'($urandom), bi, oe);
        acc = {acc[NB-2:0], bi};
        anyoe = anyoe | oe;
        if (sv_mid && w == 0 && b == 4)
          load_ch({$urandom, $urandom});
      end
      rx_w[w] = acc[NB-1 -: W];
      rx_p[w] = acc[0];
      if (cmd[7]) begin
        ew = mword(p);
        chk("word", 32'(rx_w[w]), 32'(ew));
`ifdef SPI_SENSOR_PARITY_EN
        chk("parity", 32'(rx_p[w]), 32'(^ew));
`endif
        p = (p >= CH - 1) ? 0 : p + 1;
      end
    end
    spi_end(m);
    if (cmd[7]) begin
      chk("word_done_cnt", 32'(wd_cnt[m] - wd0), 32'(nw));
      chk("word_count", 32'(m ? wc1 : wc0), 32'(nw));
    end else begin
      chk("ignore_oe", 32'(anyoe), 32'd0);
      chk("ignore_wd", 32'(wd_cnt[m] - wd0), 32'd0);
      chk("ignore_wc", 32'(m ? wc1 : wc0), 32'd0);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wd0, nw;
    logic b, o, anyoe;
    logic [7:0] cmd;
    for (int k = 0; k < CH; k++) live[k] = '0;
    q(4);
    chk("rst_sdo", 32'(sdo), 32'd0);
    chk("rst_oe", 32'(sdo_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wd", 32'(word_done), 32'd0);
    chk("rst_wc", 32'({wc1, wc0}), 32'd0);
    reset = 1'b0;
    q(4);

    load_ch({16'h8001, 16'h0F0F, 16'hABCD, 16'h1234});
    xfer(1'b0, 8'h81, 1, 1'b0);
    chk("single_w0", 32'(rx_w[0]), 32'hABCD);
`ifdef SPI_SENSOR_PARITY_EN
    chk("par_abcd", 32'(rx_p[0]), 32'd0);
`endif

    xfer(1'b0, 8'h83, 3, 1'b0);
    chk("burst_w0", 32'(rx_w[0]), 32'h8001);
    chk("burst_w1", 32'(rx_w[1]), 32'h1234);
    chk("burst_w2", 32'(rx_w[2]), 32'hABCD);
`ifdef SPI_SENSOR_PARITY_EN
    chk("par_8001", 32'(rx_p[0]), 32'd0);
`endif

    xfer(1'b0, 8'h87, 2, 1'b1);
    chk("oor_w0", 32'(rx_w[0]), 32'h0000);
    chk("oor_w1", 32'(rx_w[1]), 32'h1234);

    load_ch({16'h8001, 16'h0F0F, 16'hABCD, 16'h1234});
    xfer(1'b1, 8'h05, 1, 1'b0);
    xfer(1'b1, 8'h80, 1, 1'b0);
    chk("m3_w0", 32'(rx_w[0]), 32'h1234);

    spi_begin(1'b0);
    spi_cmd(1'b0, 8'h81);
    wd0 = wd_cnt[0];
    for (int i = 0; i < 5; i++) spi_bit(1'b0, 1'b1, b, o);
    @(posedge clk);
    #2;
    csb[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy2", 32'(busy[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("abort_busy3", 32'(busy[0]), 32'd0);
    q(H);
    chk("abort_wd", 32'(wd_cnt[0] - wd0), 32'd0);
    chk("abort_wc", 32'(wc0), 32'd0);

    spi_begin(1'b0);
    spi_cmd(1'b0, 8'h81);
    wd0 = wd_cnt[0];
    for (int i = 0; i < 3; i++) spi_bit(1'b0, 1'b0, b, o);
    chk("pre_rst_oe", 32'(sdo_oe[0]), 32'd1);
    chk("pre_rst_busy", 32'(busy[0]), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_sdo", 32'(sdo[0]), 32'd0);
    chk("mid_rst_oe", 32'(sdo_oe[0]), 32'd0);
    chk("mid_rst_busy", 32'(busy[0]), 32'd0);
    chk("mid_rst_wd", 32'(word_done[0]), 32'd0);
    chk("mid_rst_wc", 32'(wc0), 32'd0);
    #1;
    reset = 1'b0;
    for (int k = 0; k < CH; k++) live[k] = '0;
    anyoe = 1'b0;
    for (int i = 0; i < 13; i++) begin
      spi_bit(1'b0, 1'b1, b, o);
      anyoe = anyoe | o;
    end
    spi_end(1'b0);
    chk("post_rst_oe", 32'(anyoe), 32'd0);
    chk("post_rst_wd", 32'(wd_cnt[0] - wd0), 32'd0);

    load_ch({16'h8001, 16'h0F0F, 16'hABCD, 16'h0001});
    xfer(1'b0, 8'h82, 1, 1'b0);
    chk("recover_w0", 32'(rx_w[0]), 32'h0F0F);
    xfer(1'b0, 8'h80, 1, 1'b0);
    chk("w_0001", 32'(rx_w[0]), 32'h0001);
`ifdef SPI_SENSOR_PARITY_EN
    chk("par_0001", 32'(rx_p[0]), 32'd1);
`endif

    for (int t = 0; t < 24; t++) begin
      if ($urandom % 2 == 0) load_ch({$urandom, $urandom});
      cmd = 8'($urandom);
      if ($urandom % 4 != 0) cmd[7] = 1'b1;
      nw = 1 + int'($urandom % 4);
      xfer(1'($urandom), cmd, nw, 1'($urandom));
      q(3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/spi_sensor_slave.md
# spi_sensor_slave

Synthesizable, parametrised SPI slave that emulates a multi-channel sensor (microphone/ADC front end) for Ravenna SoC system simulation and FPGA emulation. It succeeds the single-channel behavioural SPI test responder on the SoC's `spi_*` master pins. It oversamples `csb`/`sck`/`sdi` on the system clock, accepts a read command byte, and streams channel samples MSB-first with channel auto-increment. Samples come from a parallel bus supplied by the bench or an upstream stimulus generator.

## Interface
- `WIDTH`, 16: bits per sample word, 8..32.
- `CHANNELS`, 4: number of sample channels, 1..16.
- `MODE`, 0: SPI mode; bit1 is CPOL, bit0 is CPHA.

- `clk`  in  1  system clock; single clock domain. Must run at least 8x the `sck` frequency.
- `reset`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle strobe that loads `sample_data` into the live registers.
- `sample_data`  in  CHANNELS*WIDTH  channel k occupies `[k*WIDTH +: WIDTH]`.
- `csb`  in  1  SPI chip select, active low, asynchronous to `clk`.
- `sck`  in  1  SPI clock, asynchronous to `clk`.
- `sdi`  in  1  SPI data from master, asynchronous to `clk`.
- `sdo`  out  1  SPI data to master.
- `sdo_oe`  out  1  output enable for `sdo`; the pad is high-Z when low.
- `busy`  out  1  high while a transaction is active (state other than IDLE).
- `word_done`  out  1  one-cycle pulse after the last bit of each complete data word.
- `word_count`  out  8  number of data words completed in the current transaction; saturates at 255.

## Operation
- **Input synchronisation.** `csb`, `sck` and `sdi` each pass through a 2-flop synchroniser. Edges are detected on the synchronised `sck`.
  - Leading edge: the edge away from CPOL.
  - Trailing edge: the edge back to CPOL.
  - Sample edge: leading if CPHA=0, trailing if CPHA=1. The shift edge is the other one.
- **Live registers.** On `sample_valid`, all CHANNELS live registers load. They update regardless of transaction state.
- **Snapshot.** On the synchronised `csb` falling edge, all live registers copy into the snapshot registers. A burst therefore always returns a coherent sample set.
- **States:** IDLE, CMD, DATA, IGNORE.
  - IDLE → CMD on `csb` fall. Bit counter is cleared and `word_count` is set to 0.
  - CMD: shifts `sdi` in MSB-first on each sample edge. After the 8th bit, the command byte is decoded:
    - bit7=1: read. The channel pointer is set to bits[3:0], and the state goes to DATA.
    - bit7=0: go to IGNORE.
  - DATA: the first sample word is loaded into the shift register on the next shift edge, and its MSB is driven on that edge.
    - Each subsequent shift edge presents the next bit.
    - After WIDTH bits have been sampled, `word_done` pulses and `word_count` increments.
    - The pointer increments, wrapping from CHANNELS-1 to 0, and the next word loads on the following shift edge.
  - IGNORE: `sdo_oe` stays 0 until `csb` rises.
  - Any state → IDLE on `csb` rise. A partial word is discarded with no `word_done`.
- **Out-of-range channel.** A pointer ≥ CHANNELS returns an all-zeros word, and the next pointer is 0.
- **Output enable.** `sdo_oe` = 1 only in DATA. `sdo` = 0 whenever `sdo_oe` = 0.
- **Edge cases.**
  - `sample_valid` in the same cycle as `csb` fall: the snapshot takes the old live values, and the new values are live for the next transaction.
  - `reset` mid-transaction: the block returns to IDLE immediately, and SPI activity is ignored until the next `csb` fall.

## Timing
- **Reset values:** `sdo`=0, `sdo_oe`=0, `busy`=0, `word_done`=0, `word_count`=0. Live and snapshot registers reset to 0.
- **Input-to-action latency:** 3 `clk` cycles from a pin transition to the corresponding internal action (2 synchroniser stages plus 1 edge-detect stage). `sdo` changes 3 cycles after the physical shift edge.
- **Setup at the master:** with `clk` ≥ 8x `sck`, `sdo` is stable at least 1 `clk` before the master's sample edge.
- **`word_done`:** asserted 1 cycle after the edge that samples the last bit of a word (4 `clk` after the physical edge).
- **`busy`:** rises 3 cycles after `csb` falls and falls 3 cycles after `csb` rises.

## Configuration
- `SPI_SENSOR_PARITY_EN`, defined:
  - Each data word is followed by one extra bit, the even parity of the word (XOR of all WIDTH bits). The word therefore occupies WIDTH+1 `sck` cycles.
  - `word_done` fires after the parity bit.
- Undefined: words are exactly WIDTH bits and no parity logic is built.

## Test plan
- **Mode 0, single read:** WIDTH=16, CHANNELS=4; channels 0x1234, 0xABCD, 0x0F0F, 0x8001; command 0x81 then 16 clocks → `sdo` returns 0xABCD; `word_done` pulses once; `word_count`=1.
- **Burst with wrap:** command 0x83 then 48 clocks → 0x8001, 0x1234, 0xABCD; `word_count`=3.
- **Out-of-range and snapshot coherence:** command 0x87 returns 0x0000, then 0x1234 follows. `sample_valid` pulsed mid-burst with new data does not change the returned words.
- **Non-read command and mode 3:** MODE=3, command 0x05 → `sdo_oe` stays 0 for the whole transaction. A second transaction with command 0x80 returns 0x1234 correctly in mode 3.
- **Abort and reset:** `csb` raised after 5 data bits → no `word_done`, `busy` low 3 cycles later. `reset` asserted mid-DATA → all outputs at reset values the next cycle.
- **Parity (`SPI_SENSOR_PARITY_EN` defined):** reading 0xABCD yields a 17th bit of 0 (ten 1-bits). Reading 0x8001 yields 0 (two 1-bits), and reading 0x0001 yields 1.
